// File: rtl/fb_port_scheduler.sv
// fb_port_scheduler: owns the single-port framebuffer RAM, sharing it between queued PPU writes and VGA line prefetch.
// Latency: accepted write reaches the RAM 1 cycle later at best; a row fetch completes 258 cycles after fetch_start, 321 with every write slot taken.
// Backpressure: wr_ready = !full (low during reset); fetch reads yield one write slot after FETCH_BURST reads while writes are queued.

// Small synchronous FIFO with an occupancy counter, storage left unreset.
module fb_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      level,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // Entry storage; contents are only meaningful between push and pop.
  always_ff @(posedge pixel_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module fb_port_scheduler #(
  parameter int         FIFO_DEPTH  = 16,
  parameter int         FETCH_BURST = 4,
  parameter logic [7:0] BLANK_IDX   = 8'h0F,
  localparam int        LW = $clog2(FIFO_DEPTH) + 1,
  localparam int        BW = $clog2(FETCH_BURST + 1)
) (
  input  logic          pixel_clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [8:0]    wr_x,
  input  logic [8:0]    wr_y,
  input  logic [7:0]    wr_data,
  input  logic          fetch_start,
  input  logic [7:0]    fetch_row,
  output logic          fetch_busy,
  output logic          fetch_done,
  output logic          err_overlap,
  output logic [LW-1:0] fifo_level,
  output logic          lb_we,
  output logic [7:0]    lb_addr,
  output logic [7:0]    lb_data,
  output logic [15:0]   ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, BLANK} state_t;

  state_t        state, state_nxt;
  logic [7:0]    row, row_nxt;
  logic [7:0]    rd_idx, rd_idx_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          do_read;
  logic          blank_wr;
  logic          done_nxt;
  logic          overlap_set;
  logic          force_wr;
  logic          lb_blank;

  logic          fifo_push;
  logic          fifo_pop;
  logic [23:0]   fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;
  logic          wr_in_range;

  // Off-screen pixels still complete their handshake but are never queued.
  assign wr_ready    = !fifo_full && !reset;
  assign wr_in_range = !wr_x[8] && (wr_y < 9'd240);
  assign fifo_push   = wr_valid && wr_ready && wr_in_range;

  fb_sync_fifo #(.WIDTH(24), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({wr_y[7:0], wr_x[7:0], wr_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // A write slot is forced only once a full burst of reads has gone out and a write is waiting.
  assign force_wr   = (burst_cnt == BW'(FETCH_BURST)) && !fifo_empty;
  assign fetch_busy = (state != IDLE);
  // Blank rows bypass the RAM, so the line buffer takes the constant instead of ram_dout.
  assign lb_data    = lb_we ? (lb_blank ? BLANK_IDX : ram_dout) : 8'h00;

  // Next-state and the per-cycle RAM arbitration: fetch read first, otherwise drain one queued write.
  always_comb begin
    state_nxt   = state;
    row_nxt     = row;
    rd_idx_nxt  = rd_idx;
    burst_nxt   = burst_cnt;
    do_read     = 1'b0;
    blank_wr    = 1'b0;
    done_nxt    = 1'b0;
    overlap_set = 1'b0;
    fifo_pop    = 1'b0;
    ram_addr    = 16'h0000;
    ram_we      = 1'b0;
    ram_din     = 8'h00;

    case (state)
      IDLE: begin
        if (fetch_start) begin
          row_nxt    = fetch_row;
          rd_idx_nxt = 8'd0;
          burst_nxt  = '0;
          state_nxt  = (fetch_row < 8'd240) ? FETCH : BLANK;
        end
      end
      FETCH: begin
        if (!force_wr) begin
          do_read    = 1'b1;
          rd_idx_nxt = rd_idx + 8'd1;
          // Saturate so a write arriving after a long uncontended run is still forced promptly.
          if (burst_cnt != BW'(FETCH_BURST)) burst_nxt = burst_cnt + BW'(1);
          if (rd_idx == 8'd255) state_nxt = DRAIN;
        end
      end
      BLANK: begin
        blank_wr   = 1'b1;
        rd_idx_nxt = rd_idx + 8'd1;
        if (rd_idx == 8'd255) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    if (fetch_start && (state != IDLE)) overlap_set = 1'b1;

    if (do_read) begin
      ram_addr = {row, rd_idx};
    end else if (!fifo_empty) begin
      fifo_pop  = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = fifo_dout[23:8];
      ram_din   = fifo_dout[7:0];
      burst_nxt = '0;
    end
  end

  // FSM state, fetch position and burst counter.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      row       <= 8'd0;
      rd_idx    <= 8'd0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      row       <= row_nxt;
      rd_idx    <= rd_idx_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Line-buffer write stage aligned with the RAM read latency, plus done pulse and sticky overlap flag.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      lb_we       <= 1'b0;
      lb_addr     <= 8'd0;
      lb_blank    <= 1'b0;
      fetch_done  <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      lb_we       <= do_read || blank_wr;
      lb_addr     <= rd_idx;
      lb_blank    <= blank_wr;
      fetch_done  <= done_nxt;
      err_overlap <= err_overlap || overlap_set;
    end
  end
endmodule

// File: tb/tb_fb_port_scheduler.sv
// Bench for fb_port_scheduler: directed vectors, scoreboard queues checked by a negedge monitor.
module tb_fb_port_scheduler;
  logic        pixel_clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [8:0]  wr_x;
  logic [8:0]  wr_y;
  logic [7:0]  wr_data;
  logic        fetch_start;
  logic [7:0]  fetch_row;
  logic        fetch_busy;
  logic        fetch_done;
  logic        err_overlap;
  logic [4:0]  fifo_level;
  logic        lb_we;
  logic [7:0]  lb_addr;
  logic [7:0]  lb_data;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  fb_port_scheduler dut (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_data     (wr_data),
    .fetch_start (fetch_start),
    .fetch_row   (fetch_row),
    .fetch_busy  (fetch_busy),
    .fetch_done  (fetch_done),
    .err_overlap (err_overlap),
    .fifo_level  (fifo_level),
    .lb_we       (lb_we),
    .lb_addr     (lb_addr),
    .lb_data     (lb_data),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int lb_cnt   = 0;
  int lb_first = -1;
  int lb_last  = -1;
  int rdy_low  = 0;
  logic feed_stop = 1'b0;
  logic ram_init  = 1'b1;

  logic [23:0] exp_wr[$];
  logic [15:0] exp_lb[$];
  logic [7:0]  mem [65536];

  always @(posedge pixel_clk) cyc <= cyc + 1;

  // Framebuffer model: synchronous read-first RAM, preloaded with data = addr[7:0].
  always @(posedge pixel_clk) begin
    if (ram_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'(i);
    end else begin
      ram_dout <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_din;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT writes the RAM or the line buffer.
  initial begin
    logic [23:0] ew;
    logic [15:0] el;
    forever begin
      @(negedge pixel_clk);
      if (!reset && !wr_ready) rdy_low++;
      if (ram_we) begin
        if (exp_wr.size() == 0) chk("ram_we_unexpected", 32'(ram_we), 32'd0);
        else begin
          ew = exp_wr.pop_front();
          chk("ram_write", 32'({ram_addr, ram_din}), 32'(ew));
        end
      end
      if (lb_we) begin
        lb_cnt++;
        if (lb_first < 0) lb_first = cyc - t0;
        lb_last = cyc - t0;
        if (exp_lb.size() == 0) chk("lb_we_unexpected", 32'(lb_we), 32'd0);
        else begin
          el = exp_lb.pop_front();
          chk("lb_write", 32'({lb_addr, lb_data}), 32'(el));
        end
      end
    end
  end

  // Called at a negedge; holds the request until accepted, leaves at the negedge after the handshake.
  task automatic send_wr(input logic [8:0] x, input logic [8:0] y, input logic [7:0] d, output logic acc);
    int k = 0;
    wr_valid = 1'b1; wr_x = x; wr_y = y; wr_data = d;
    #1;
    while (!wr_ready && k < 100) begin
      @(negedge pixel_clk); #1; k++;
    end
    acc = wr_ready;
    if (!wr_ready) chk("wr_handshake_timeout", 32'(wr_ready), 32'd1);
    else if (x < 9'd256 && y < 9'd240) exp_wr.push_back({y[7:0], x[7:0], d});
    @(negedge pixel_clk);
    wr_valid = 1'b0;
  endtask

  // Pulses fetch_start for one cycle and queues the expected line-buffer contents.
  task automatic start_fetch(input logic [7:0] r);
    fetch_start = 1'b1; fetch_row = r;
    t0 = cyc; lb_cnt = 0; lb_first = -1; lb_last = -1;
    for (int i = 0; i < 256; i++)
      exp_lb.push_back({8'(i), (r >= 8'd240) ? 8'h0F : 8'(i)});
    @(negedge pixel_clk);
    fetch_start = 1'b0;
    chk("busy_after_start", 32'(fetch_busy), 32'd1);
  endtask

  task automatic wait_done(output int dcyc, output int we_win);
    dcyc = -1; we_win = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge pixel_clk);
      if (ram_we && (cyc - t0) >= 1 && (cyc - t0) <= 319) we_win++;
      if (fetch_done) begin dcyc = cyc - t0; break; end
    end
    if (dcyc < 0) chk("fetch_done_timeout", 32'(fetch_done), 32'd1);
    else chk("busy_low_at_done", 32'(fetch_busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int dcyc, we_win;
    reset = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    fetch_start = 1'b0; fetch_row = '0;
    @(negedge pixel_clk);
    ram_init = 1'b0;
    @(negedge pixel_clk);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_lb_we", 32'(lb_we), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_fetch_busy", 32'(fetch_busy), 32'd0);
    chk("rst_fetch_done", 32'(fetch_done), 32'd0);
    chk("rst_err_overlap", 32'(err_overlap), 32'd0);
    reset = 1'b0;
    @(negedge pixel_clk);
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);

    // 1: uncontended fetch of row 5.
    start_fetch(8'd5);
    wait_done(dcyc, we_win);
    chk("t1_done_cycle", 32'(dcyc), 32'd258);
    chk("t1_lb_count", 32'(lb_cnt), 32'd256);
    chk("t1_lb_first", 32'(lb_first), 32'd2);
    chk("t1_lb_last", 32'(lb_last), 32'd257);

    // 2: single write from idle.
    @(negedge pixel_clk);
    send_wr(9'd10, 9'd3, 8'h2A, acc);
    chk("t2_ram_we", 32'(ram_we), 32'd1);
    chk("t2_ram_addr", 32'(ram_addr), 32'h030A);
    chk("t2_ram_din", 32'(ram_din), 32'h2A);
    chk("t2_level_1", 32'(fifo_level), 32'd1);
    @(negedge pixel_clk);
    chk("t2_level_0", 32'(fifo_level), 32'd0);

    // 3: fetch row 0 while a feeder keeps the write FIFO non-empty.
    rdy_low = 0; feed_stop = 1'b0;
    fork
      begin
        logic a3;
        int n = 0;
        while (!feed_stop) begin
          if (fifo_level < 5'd2) begin send_wr(9'd1, 9'd1, 8'(n), a3); n++; end
          else @(negedge pixel_clk);
        end
      end
      begin
        start_fetch(8'd0);
        wait_done(dcyc, we_win);
        feed_stop = 1'b1;
      end
    join
    chk("t3_done_cycle", 32'(dcyc), 32'd321);
    chk("t3_write_slots", 32'(we_win), 32'd63);
    chk("t3_lb_count", 32'(lb_cnt), 32'd256);
    chk("t3_wr_ready_low_cycles", 32'(rdy_low), 32'd0);
    for (int k = 0; k < 50 && fifo_level != 5'd0; k++) @(negedge pixel_clk);
    chk("t3_fifo_drained", 32'(fifo_level), 32'd0);

    // 4: off-screen writes are accepted and dropped.
    send_wr(9'd256, 9'd0, 8'h55, acc);
    chk("t4_hs_x256", 32'(acc), 32'd1);
    chk("t4_level_x256", 32'(fifo_level), 32'd0);
    send_wr(9'd0, 9'd240, 8'h66, acc);
    chk("t4_hs_y240", 32'(acc), 32'd1);
    chk("t4_level_y240", 32'(fifo_level), 32'd0);
    repeat (3) @(negedge pixel_clk);
    chk("t4_level_final", 32'(fifo_level), 32'd0);

    // 5: blank row, with an overlapping fetch_start mid-way.
    chk("t5_overlap_before", 32'(err_overlap), 32'd0);
    start_fetch(8'd240);
    repeat (50) @(negedge pixel_clk);
    fetch_start = 1'b1; fetch_row = 8'd3;
    @(negedge pixel_clk);
    fetch_start = 1'b0;
    chk("t5_overlap_set", 32'(err_overlap), 32'd1);
    chk("t5_still_busy", 32'(fetch_busy), 32'd1);
    wait_done(dcyc, we_win);
    chk("t5_done_cycle", 32'(dcyc), 32'd258);
    chk("t5_lb_count", 32'(lb_cnt), 32'd256);
    repeat (3) @(negedge pixel_clk);
    chk("t5_overlap_sticky", 32'(err_overlap), 32'd1);

    // 6: reset mid-fetch with writes queued.
    start_fetch(8'd5);
    for (int i = 0; i < 16; i++) send_wr(9'(i), 9'd7, 8'(8'hA0 + i), acc);
    #2;
    reset = 1'b1;
    exp_wr.delete();
    exp_lb.delete();
    #1;
    chk("t6_lb_we", 32'(lb_we), 32'd0);
    chk("t6_ram_we", 32'(ram_we), 32'd0);
    chk("t6_fifo_level", 32'(fifo_level), 32'd0);
    chk("t6_fetch_busy", 32'(fetch_busy), 32'd0);
    chk("t6_wr_ready", 32'(wr_ready), 32'd0);
    chk("t6_err_overlap", 32'(err_overlap), 32'd0);
    repeat (3) begin
      @(negedge pixel_clk);
      chk("t6_hold_wr_ready", 32'(wr_ready), 32'd0);
      chk("t6_hold_lb_we", 32'(lb_we), 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("t6_release_wr_ready", 32'(wr_ready), 32'd1);
    repeat (10) @(negedge pixel_clk);
    chk("t6_idle_busy", 32'(fetch_busy), 32'd0);

    chk("end_exp_wr_empty", 32'(exp_wr.size()), 32'd0);
    chk("end_exp_lb_empty", 32'(exp_lb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
